// File: rtl/pattern_search_ctrl_pkg.sv
// Shared types and default parameter values for the pattern search controller.
package pattern_search_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TMO_W   = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONFIGURED = 2'd1,
        SEARCH     = 2'd2,
        DONE       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        LIMIT   = 2'd1,
        TIMEOUT = 2'd2,
        ABORT   = 2'd3
    } end_reason_t;

endpackage

// File: rtl/pattern_search_ctrl_if.sv
// Bus bundle for the pattern search controller: config handshake, run control,
// serial bit stream and run status. Optional cfg_mask exists when
// PATTERN_MASK_EN is defined.
interface pattern_search_ctrl_if
    import pattern_search_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TMO_W   = DEF_TMO_W
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [MAX_LEN-1:0]   cfg_pattern;
    logic [LEN_W-1:0]     cfg_len;
    logic [CNT_W-1:0]     cfg_limit;
    logic [TMO_W-1:0]     cfg_timeout;
`ifdef PATTERN_MASK_EN
    logic [MAX_LEN-1:0]   cfg_mask;
`endif
    logic                 start;
    logic                 abort;
    logic                 bit_valid;
    logic                 new_bit;
    logic                 bit_ready;
    logic                 detected;
    logic [CNT_W-1:0]     match_count;
    logic                 busy;
    logic                 done;
    logic [1:0]           end_reason;

    // Host / bit-source side
    modport master (
`ifdef PATTERN_MASK_EN
        output cfg_mask,
`endif
        output cfg_valid, cfg_pattern, cfg_len, cfg_limit, cfg_timeout,
        output start, abort, bit_valid, new_bit,
        input  cfg_ready, bit_ready, detected, match_count, busy, done, end_reason
    );

    // Controller side
    modport slave (
`ifdef PATTERN_MASK_EN
        input  cfg_mask,
`endif
        input  cfg_valid, cfg_pattern, cfg_len, cfg_limit, cfg_timeout,
        input  start, abort, bit_valid, new_bit,
        output cfg_ready, bit_ready, detected, match_count, busy, done, end_reason
    );

endinterface

// File: rtl/pattern_search_ctrl_matcher.sv
// Shift register, fill counter and length-limited (optionally masked) compare.
// match_o reflects the state that would exist after the bit offered this cycle,
// so the controller can register the detection on the accepting edge.
// Optional mask input exists when PATTERN_MASK_EN is defined.
module pattern_shift_matcher #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               shift_en_i,
    input  logic               bit_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
`ifdef PATTERN_MASK_EN
    input  logic [MAX_LEN-1:0] mask_i,
`endif
    output logic               match_o
);
    logic [MAX_LEN-1:0] shift_q, shift_d, shift_nxt, care;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_nxt;

    // Candidate post-shift state, compare window and next-state selection
    always_comb begin
        shift_nxt = {shift_q[MAX_LEN-2:0], bit_i};
        fill_nxt  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        care      = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            care[i] = (i < int'(len_i));
        end
`ifdef PATTERN_MASK_EN
        care = care & mask_i;
`endif
        match_o = shift_en_i && (((shift_nxt ^ pattern_i) & care) == '0)
                  && (fill_nxt >= len_i);
        shift_d = shift_q;
        fill_d  = fill_q;
        if (clear_i) begin
            shift_d = '0;
            fill_d  = '0;
        end else if (shift_en_i) begin
            shift_d = shift_nxt;
            fill_d  = fill_nxt;
        end
    end

    // Shift register and fill counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            fill_q  <= '0;
        end else begin
            shift_q <= shift_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/pattern_search_ctrl.sv
// Pattern search run controller: config capture, run FSM, match/timeout
// counters and status outputs. Define PATTERN_MASK_EN to add a per-bit
// don't-care mask to the compare.
module pattern_search_ctrl
    import pattern_search_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TMO_W   = DEF_TMO_W
) (
    input  logic               clk,
    input  logic               rst_n,
    pattern_search_ctrl_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    // Zero length means a single bit; anything beyond the register is clamped.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
        if (len == '0) return LEN_W'(1);
        if (int'(len) > MAX_LEN) return LEN_W'(MAX_LEN);
        return len;
    endfunction

    state_t             state_q, state_d;
    end_reason_t        reason_q, reason_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   limit_q, limit_d, cnt_q, cnt_d, cnt_inc;
    logic [TMO_W-1:0]   tlim_q, tlim_d, tmo_q, tmo_d, tmo_inc;
    logic               det_q, det_d;
    logic               clear, shift_en, match;
`ifdef PATTERN_MASK_EN
    logic [MAX_LEN-1:0] mask_q, mask_d;
`endif

    assign clear    = (state_q == CONFIGURED) && !bus.cfg_valid && bus.start;
    assign shift_en = (state_q == SEARCH) && bus.bit_valid;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign tmo_inc  = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;

    pattern_shift_matcher #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_matcher (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .shift_en_i(shift_en),
        .bit_i     (bus.new_bit),
        .pattern_i (pat_q),
        .len_i     (len_q),
`ifdef PATTERN_MASK_EN
        .mask_i    (mask_q),
`endif
        .match_o   (match)
    );

    // Next-state, config capture, counters and end-reason arbitration
    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        pat_d    = pat_q;
        len_d    = len_q;
        limit_d  = limit_q;
        tlim_d   = tlim_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        det_d    = 1'b0;
`ifdef PATTERN_MASK_EN
        mask_d   = mask_q;
`endif
        case (state_q)
            IDLE, CONFIGURED: begin
                if (bus.cfg_valid) begin
                    pat_d   = bus.cfg_pattern;
                    len_d   = norm_len(bus.cfg_len);
                    limit_d = bus.cfg_limit;
                    tlim_d  = bus.cfg_timeout;
`ifdef PATTERN_MASK_EN
                    mask_d  = bus.cfg_mask;
`endif
                    state_d = CONFIGURED;
                end else if (clear) begin
                    cnt_d    = '0;
                    tmo_d    = '0;
                    reason_d = NONE;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                // A match restarts the idle window, so it also masks a timeout.
                if (match) begin
                    det_d = 1'b1;
                    cnt_d = cnt_inc;
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
                if (match && (limit_q != '0) && (cnt_inc == limit_q)) begin
                    reason_d = LIMIT;
                    state_d  = DONE;
                end else if (bus.abort) begin
                    reason_d = ABORT;
                    state_d  = DONE;
                end else if (!match && (tlim_q != '0) && (tmo_inc == tlim_q)) begin
                    reason_d = TIMEOUT;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = CONFIGURED;
            default: state_d = IDLE;
        endcase
    end

    // Controller state, config and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            reason_q <= NONE;
            pat_q    <= '0;
            len_q    <= '0;
            limit_q  <= '0;
            tlim_q   <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            det_q    <= 1'b0;
`ifdef PATTERN_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            limit_q  <= limit_d;
            tlim_q   <= tlim_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            det_q    <= det_d;
`ifdef PATTERN_MASK_EN
            mask_q   <= mask_d;
`endif
        end
    end

    assign bus.cfg_ready   = (state_q == IDLE) || (state_q == CONFIGURED);
    assign bus.busy        = (state_q == SEARCH);
    assign bus.bit_ready   = (state_q == SEARCH);
    assign bus.done        = (state_q == DONE);
    assign bus.detected    = det_q;
    assign bus.match_count = cnt_q;
    assign bus.end_reason  = reason_q;

endmodule
